// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM states,
// width limits and the layout of one receive-FIFO word.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int MIN_DATA_W = 5;
  localparam int MAX_DATA_W = 9;
  localparam int CFG_BITS_W = 4;

  // FIFO word = {data, parity_err, frame_err, break_det}, status in the low bits.
  localparam int W_BRK  = 0;
  localparam int W_FRM  = 1;
  localparam int W_PAR  = 2;
  localparam int W_DATA = 3;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side head-of-FIFO handshake: one character plus its status flags.
interface uart_rx_cfg_if #(
  parameter int DATA_W = 8
) ();
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              parity_err;
  logic              frame_err;
  logic              break_det;

  modport master (output rx_valid, rx_data, parity_err, frame_err, break_det,
                  input  rx_ready);
  modport slave  (input  rx_valid, rx_data, parity_err, frame_err, break_det,
                  output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with a sticky overrun flag
// that is set by a dropped push and cleared by the next pop.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full      = (count_q == (AW+1)'(DEPTH));
    do_pop    = pop && (count_q != '0);
    // A pop on the same edge frees the slot the push lands in.
    do_push   = push && (!full || do_pop);
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
    overrun_d = overrun_q;
    if (do_pop)             overrun_d = 1'b0;
    else if (push && full)  overrun_d = 1'b1;
  end

  // NOTE: storage is deliberately not reset; count_q alone says which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign level      = count_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with per-frame latched format, 3-sample majority voting,
// break detection and a small first-word-fall-through receive FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        oversample_tick,
  input  logic                        rx,
  input  logic [CFG_BITS_W-1:0]       cfg_data_bits,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        cfg_stop2,
  uart_rx_cfg_if.master               rx_if,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int TW     = $clog2(OVS);
  localparam int WORD_W = DATA_W + W_DATA;
  localparam logic [TW-1:0] T_S0  = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVS/2);
  localparam logic [TW-1:0] T_DEC = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);

  rx_state_e             state_q, state_d;
  logic [1:0]            sync_q, sync_d, fill_q, fill_d, samp_q, samp_d;
  logic                  seen_high_q, seen_high_d;
  logic [TW-1:0]         tick_q, tick_d, tick_nxt;
  logic [CFG_BITS_W-1:0] bit_q, bit_d, cfg_bits_q, cfg_bits_d;
  logic                  stop_idx_q, stop_idx_d, par_bit_q, par_bit_d;
  logic                  frame_err_q, frame_err_d;
  logic                  par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic [DATA_W-1:0]     shift_q, shift_d, data_al;
  logic                  rx_s, maj, bit_end, push, head_valid;
  logic [WORD_W-1:0]     push_word, head_word;

  assign rx_s = sync_q[1];

  // NOTE: every _d gets its hold value first, so no branch can infer a latch.
  always_comb begin
    sync_d      = {sync_q[0], rx};
    fill_d      = {fill_q[0], 1'b1};
    // The reset value of the synchroniser must not count as having seen idle.
    seen_high_d = seen_high_q | (fill_q[1] & rx_s);
    state_d     = state_q;
    tick_d      = tick_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    frame_err_d = frame_err_q;
    cfg_bits_d  = cfg_bits_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop2_d     = stop2_q;
    push        = 1'b0;
    push_word   = '0;
    maj         = majority3(samp_q[1], samp_q[0], rx_s);
    bit_end     = (tick_q == T_END);
    tick_nxt    = bit_end ? '0 : tick_q + 1'b1;
    data_al     = shift_q >> (DATA_W - int'(cfg_bits_q));

    if (oversample_tick) begin
      if (tick_q == T_S0) samp_d[1] = rx_s;
      if (tick_q == T_S1) samp_d[0] = rx_s;
      unique case (state_q)
        IDLE: if (!rx_s && seen_high_q) begin
          state_d     = START;
          tick_d      = TW'(1);
          bit_d       = '0;
          stop_idx_d  = 1'b0;
          shift_d     = '0;
          par_bit_d   = 1'b0;
          frame_err_d = 1'b0;
          par_en_d    = parity_en;
          par_odd_d   = parity_odd;
          stop2_d     = cfg_stop2;
          if (cfg_data_bits < CFG_BITS_W'(MIN_DATA_W))  cfg_bits_d = CFG_BITS_W'(MIN_DATA_W);
          else if (cfg_data_bits > CFG_BITS_W'(DATA_W)) cfg_bits_d = CFG_BITS_W'(DATA_W);
          else                                          cfg_bits_d = cfg_data_bits;
        end
        START: begin
          tick_d = tick_nxt;
          if (tick_q == T_DEC && maj) begin
            state_d = IDLE;
            tick_d  = '0;
          end else if (bit_end) begin
            state_d = DATA;
          end
        end
        DATA: begin
          tick_d = tick_nxt;
          // Bits enter at the top so the first (LSB) ends up lowest after alignment.
          if (tick_q == T_DEC) shift_d = {maj, shift_q[DATA_W-1:1]};
          if (bit_end) begin
            if (bit_q == cfg_bits_q - 1'b1) begin
              bit_d   = '0;
              state_d = par_en_q ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        PARITY: begin
          tick_d = tick_nxt;
          if (tick_q == T_DEC) par_bit_d = maj;
          if (bit_end) state_d = STOP;
        end
        STOP: begin
          tick_d = tick_nxt;
          if (tick_q == T_DEC) begin
            if (!stop_idx_q && !maj && shift_q == '0 && !(par_en_q && par_bit_q)) begin
              push              = 1'b1;
              push_word[W_FRM]  = 1'b1;
              push_word[W_BRK]  = 1'b1;
              state_d           = BREAK;
              tick_d            = '0;
            end else if (stop_idx_q || !stop2_q) begin
              push                          = 1'b1;
              push_word[W_DATA +: DATA_W]   = data_al;
              push_word[W_PAR]              = par_en_q & (par_bit_q != ((^data_al) ^ par_odd_q));
              push_word[W_FRM]              = frame_err_q | !maj;
              state_d                       = IDLE;
              tick_d                        = '0;
            end else begin
              frame_err_d = !maj;
            end
          end else if (bit_end) begin
            stop_idx_d = 1'b1;
          end
        end
        BREAK: begin
          tick_d = rx_s ? tick_nxt : '0;
          if (rx_s && bit_end) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  // NOTE: state flops use <= so each one samples values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 2'b11;
      fill_q      <= '0;
      seen_high_q <= 1'b0;
      state_q     <= IDLE;
      tick_q      <= '0;
      samp_q      <= '0;
      bit_q       <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cfg_bits_q  <= CFG_BITS_W'(DATA_W);
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      fill_q      <= fill_d;
      seen_high_q <= seen_high_d;
      state_q     <= state_d;
      tick_q      <= tick_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      frame_err_q <= frame_err_d;
      cfg_bits_q  <= cfg_bits_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      stop2_q     <= stop2_d;
    end
  end

  uart_rx_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_word),
    .pop        (head_valid & rx_if.rx_ready),
    .head_valid (head_valid),
    .head_data  (head_word),
    .level      (fifo_level),
    .overrun    (overrun)
  );

  assign rx_if.rx_valid   = head_valid;
  assign rx_if.rx_data    = head_word[W_DATA +: DATA_W];
  assign rx_if.parity_err = head_word[W_PAR];
  assign rx_if.frame_err  = head_word[W_FRM];
  assign rx_if.break_det  = head_word[W_BRK];

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: a line driver, an expected-word queue
// model checked on every valid cycle, and literal spot checks per scenario.
module tb_uart_rx_cfg;
  localparam int DATA_W   = 8;
  localparam int OVS      = 16;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 27;                 // 50 MHz / (16 * 115200) ~= 27
  localparam int BIT_CLKS = OVS * TICK_DIV;
  localparam int WORD_W   = DATA_W + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] cfg_bits = 4'd8;
  logic       par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0;
  logic       overrun;
  logic [2:0] level;
  int         tdiv = 0;

  uart_rx_cfg_if #(.DATA_W(DATA_W)) rx_if ();

  uart_rx_cfg #(.DATA_W(DATA_W), .OVS(OVS), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .oversample_tick (tick),
    .rx              (rx),
    .cfg_data_bits   (cfg_bits),
    .parity_en       (par_en),
    .parity_odd      (par_odd),
    .cfg_stop2       (stop2),
    .rx_if           (rx_if),
    .overrun         (overrun),
    .fifo_level      (level)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    tdiv <= (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
    tick <= (tdiv == TICK_DIV - 1);
  end

  // Model: words the line should deliver, in order, capped at DEPTH.
  logic [WORD_W-1:0] exp_q[$];
  logic              exp_ovr = 1'b0;
  int                n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] word_of(input logic [DATA_W-1:0] d,
                                               input logic pe, input logic fe, input logic bd);
    return {d, pe, fe, bd};
  endfunction

  task automatic push_expect(input logic [WORD_W-1:0] w);
    if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (!reset && rx_if.rx_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {rx_if.rx_data, rx_if.parity_err, rx_if.frame_err, rx_if.break_det}, 32'hFFFF_FFFF);
      end else begin
        check("head_word", {rx_if.rx_data, rx_if.parity_err, rx_if.frame_err, rx_if.break_det}, exp_q[0]);
        if (rx_if.rx_ready) begin
          void'(exp_q.pop_front());
          exp_ovr = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    cyc(BIT_CLKS);
  endtask

  // One frame in the current format; glitch_bit >= 0 flips that data bit briefly
  // (shorter than a tick, so at most one of the three votes can see it).
  task automatic send_frame(input logic [DATA_W-1:0] d, input bit bad_par,
                            input bit stop2_low, input int glitch_bit);
    logic [DATA_W-1:0] mask, dm;
    logic              pbit;
    mask = '0;
    for (int i = 0; i < int'(cfg_bits); i++) mask[i] = 1'b1;
    dm   = d & mask;
    pbit = (^dm) ^ par_odd ^ bad_par;
    push_expect(word_of(dm, par_en && (pbit != ((^dm) ^ par_odd)), stop2 && stop2_low, 1'b0));
    drive_bit(1'b0);
    for (int i = 0; i < int'(cfg_bits); i++) begin
      if (i == glitch_bit) begin
        rx = dm[i];  cyc(8 * TICK_DIV + 10);
        rx = ~dm[i]; cyc(20);
        rx = dm[i];  cyc(BIT_CLKS - 8 * TICK_DIV - 30);
      end else begin
        drive_bit(dm[i]);
      end
    end
    if (par_en) drive_bit(pbit);
    drive_bit(1'b1);
    if (stop2) drive_bit(!stop2_low);
    rx = 1'b1;
  endtask

  task automatic expect_head(input string tag, input logic [7:0] d,
                             input logic pe, input logic fe, input logic bd);
    cyc(BIT_CLKS);
    check({tag, "_level"}, level, 1);
    check({tag, "_valid"}, rx_if.rx_valid, 1);
    check({tag, "_data"}, rx_if.rx_data, d);
    check({tag, "_perr"}, rx_if.parity_err, pe);
    check({tag, "_ferr"}, rx_if.frame_err, fe);
    check({tag, "_brk"}, rx_if.break_det, bd);
    rx_if.rx_ready = 1'b1;
    cyc(2);
    rx_if.rx_ready = 1'b0;
    check({tag, "_drained"}, level, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, rx_if.rx_valid, 0);
    check({tag, "_data"}, rx_if.rx_data, 0);
    check({tag, "_status"}, {rx_if.parity_err, rx_if.frame_err, rx_if.break_det, overrun}, 0);
    check({tag, "_level"}, level, 0);
  endtask

  initial begin
    rx_if.rx_ready = 1'b0;
    cyc(6);
    check_reset_state("reset");
    reset = 1'b0;
    cyc(BIT_CLKS);

    // 8N1 0x55, held in the FIFO
    send_frame(8'h55, 1'b0, 1'b0, -1);
    expect_head("8n1_55", 8'h55, 1'b0, 1'b0, 1'b0);

    // 7E1 0x3A with the parity bit inverted
    cfg_bits = 4'd7; par_en = 1'b1; par_odd = 1'b0;
    send_frame(8'h3A, 1'b1, 1'b0, -1);
    expect_head("7e1_3a", 8'h3A, 1'b1, 1'b0, 1'b0);

    // 8E2 0xA5 with second stop bit low
    cfg_bits = 4'd8; stop2 = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    expect_head("8e2_a5", 8'hA5, 1'b0, 1'b1, 1'b0);

    // break: 8N1 line low for ten bit times
    par_en = 1'b0; stop2 = 1'b0;
    push_expect(word_of('0, 1'b0, 1'b1, 1'b1));
    rx = 1'b0;
    cyc(10 * BIT_CLKS);
    rx = 1'b1;
    expect_head("break", 8'h00, 1'b0, 1'b1, 1'b1);
    cyc(2 * BIT_CLKS);
    check("break_single", level, 0);

    // quarter-bit glitch on an idle line
    rx = 1'b0;
    cyc(BIT_CLKS / 4);
    rx = 1'b1;
    cyc(2 * BIT_CLKS);
    check("idle_glitch_level", level, 0);
    check("idle_glitch_valid", rx_if.rx_valid, 0);

    // sub-tick glitch in the middle of data bit 3
    send_frame(8'h96, 1'b0, 1'b0, 3);
    expect_head("mid_glitch", 8'h96, 1'b0, 1'b0, 1'b0);

    // overrun: five bytes, nobody reading
    for (int i = 1; i <= 5; i++) begin
      send_frame(DATA_W'(i), 1'b0, 1'b0, -1);
      cyc(BIT_CLKS / 2);
    end
    check("ovr_level", level, 4);
    check("ovr_level_model", level, exp_q.size());
    check("ovr_flag", overrun, 1);
    check("ovr_flag_model", overrun, exp_ovr);
    check("ovr_head", rx_if.rx_data, 8'h01);
    rx_if.rx_ready = 1'b1;
    cyc(1);
    rx_if.rx_ready = 1'b0;
    cyc(1);
    check("ovr_cleared", overrun, 0);
    check("ovr_after_pop", level, 3);
    check("ovr_head2", rx_if.rx_data, 8'h02);
    rx_if.rx_ready = 1'b1;
    cyc(8);
    check("ovr_drained", level, 0);

    // reset in the middle of 0xC3's data bits, released while the line is low
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx = 1'b0;
    cyc(BIT_CLKS / 2);
    reset = 1'b1;
    cyc(4);
    exp_q.delete();
    exp_ovr = 1'b0;
    check_reset_state("midreset");
    reset = 1'b0;
    cyc(2 * BIT_CLKS);
    check("held_low_level", level, 0);
    rx = 1'b1;
    cyc(2 * BIT_CLKS);
    check("after_release_level", level, 0);
    rx_if.rx_ready = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b0, -1);
    expect_head("post_reset_c3", 8'hC3, 1'b0, 1'b0, 1'b0);

    cyc(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, maximum data bits per character (5..9).
REQ-002 SHALL have parameter OVS, default 16, oversample ticks per bit (even, 8..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  single clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port oversample_tick  in  1  one-clk pulse at OVS x baud.
REQ-007 SHALL have port rx  in  1  asynchronous serial line, idle high.
REQ-008 SHALL have port cfg_data_bits  in  4  data bits per character, 5..DATA_W.
REQ-009 SHALL have ports parity_en, parity_odd, cfg_stop2  in  1 each  parity enable, odd select, two stop bits.
REQ-010 SHALL have ports rx_valid out 1 and rx_ready in 1  FIFO head handshake.
REQ-011 SHALL have port rx_data  out  DATA_W  head character, LSB-aligned, unused upper bits 0.
REQ-012 SHALL have ports parity_err, frame_err, break_det  out  1 each  status of head character.
REQ-013 SHALL have ports overrun out 1 (sticky) and fifo_level out $clog2(FIFO_DEPTH)+1.

Function
REQ-014 rx SHALL pass through a 2-flop synchroniser; all logic uses the synchronised value.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; tick counter counts oversample_tick 0..OVS-1 per bit.
REQ-016 IDLE->START on synchronised rx low; config inputs SHALL be latched on this transition, mid-frame changes ignored.
REQ-017 Each bit SHALL be the majority of samples at ticks OVS/2-1, OVS/2, OVS/2+1 (counted from bit start).
REQ-018 START with majority 1 SHALL return to IDLE with no push (false start).
REQ-019 DATA SHALL shift LSB first for latched cfg_data_bits bits; PARITY only when parity_en; parity_err = received parity != even/odd parity of data.
REQ-020 STOP SHALL check one or two (cfg_stop2) stop bits; any stop bit majority 0 sets frame_err for the character.
REQ-021 If data, parity (if enabled) and first stop bit are all 0, character SHALL carry break_det=1, frame_err=1, data 0, then FSM enters BREAK until rx high for a full bit time, then IDLE.
REQ-022 Push of {data, parity_err, frame_err, break_det} SHALL occur on the clk of the last stop-bit majority decision (first stop bit on break); FSM returns to IDLE same cycle for resync.
REQ-023 Pushed word SHALL appear on rx_valid/outputs the clk after push (1-cycle latency when empty).
REQ-024 Pop SHALL occur when rx_valid & rx_ready; outputs hold stable while rx_valid & !rx_ready.
REQ-025 Push when full and no pop: word dropped, overrun set; overrun clears on next pop.
REQ-026 Simultaneous push and pop when full SHALL accept the push, no overrun, fifo_level unchanged.
REQ-027 fifo_level SHALL equal stored entries, 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 Reset SHALL set FSM IDLE, counters 0, FIFO empty, rx_valid 0, rx_data 0, all status outputs 0, fifo_level 0, synchroniser flops 1.
REQ-029 Reset mid-frame SHALL discard the partial character; after reset, START is not entered until rx has been seen high at least once.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state enum, max-width constants and FIFO word layout.
REQ-031 FIFO SHALL be a sub-module uart_rx_fifo (synchronous, first-word-fall-through, parametrised width/depth).

Verification
REQ-032 8N1, byte 0x55 from uart_tx at 115200/50 MHz -> one word 0x55, all errors 0, fifo_level 1.
REQ-033 7 data bits, even parity, wrong parity bit on 0x3A -> rx_data 0x3A, parity_err 1.
REQ-034 8E2, second stop bit forced low on 0xA5 -> 0xA5, frame_err 1; 10-bit-time low line -> break_det 1, data 0, single word.
REQ-035 rx_ready held 0, FIFO_DEPTH+1 bytes 0x01..0x05 -> FIFO holds 0x01..0x04, overrun 1; one pop clears overrun.
REQ-036 1/4-bit low glitch on idle line -> no push; single-tick glitch mid-bit -> correct byte (majority).
REQ-037 reset asserted mid-DATA of 0xC3 then released while rx low -> no word until next full frame, which decodes correctly.
